// File: rtl/tinyqv_lsu_pkg.sv
// Shared definitions for the TinyQV load/store unit: FSM state encoding and
// memory request size codes.
package tinyqv_lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_STORE_REQ  = 3'd1,
    ST_LOAD_REQ   = 3'd2,
    ST_LOAD_WAIT  = 3'd3,
    ST_LOAD_HOLD  = 3'd4,
    ST_LOAD_DATA  = 3'd5
  } lsu_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // mem_op[2] is the load sign flag; the memory side only sees the size.
  function automatic logic [1:0] op_to_size(input logic [2:0] mem_op);
    casez (mem_op)
      3'b?00:  return SZ_BYTE;
      3'b?01:  return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/tinyqv_nibble_sreg.sv
// 32-bit shift register fed one nibble per clock, LSB nibble first.
// shifted_o is the word as it will be after the current clock edge.
module tinyqv_nibble_sreg (
  input  logic        clk,
  input  logic [3:0]  nibble_i,
  output logic [31:0] shifted_o
);

  logic [31:0] sreg_q;

  assign shifted_o = {nibble_i, sreg_q[31:4]};

  always_ff @(posedge clk) begin
    sreg_q <= shifted_o;
  end

endmodule

// File: rtl/tinyqv_lsu.sv
// TinyQV load/store unit: turns nibble-serial core accesses into single
// 32-bit memory requests and streams load data back one nibble per clock.
//
// state        | meaning
// ST_IDLE      | no access in flight, accepts address_ready
// ST_STORE_REQ | store request presented, waiting for mem_req_ready
// ST_LOAD_REQ  | load request presented, waiting for mem_req_ready
// ST_LOAD_WAIT | load accepted, waiting for mem_rvalid
// ST_LOAD_HOLD | load data buffered, waiting for counter wrap
// ST_LOAD_DATA | returning buffered data, one nibble per counter step
module tinyqv_lsu
  import tinyqv_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  counter_i,
  input  logic        address_ready_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [2:0]  mem_op_i,
  input  logic [27:0] addr_in_i,
  input  logic [3:0]  store_nibble_i,
  output logic        load_data_ready_o,
  output logic [3:0]  load_nibble_o,
  output logic        busy_o,
  output logic        mem_req_valid_o,
  output logic        mem_req_write_o,
  output logic [1:0]  mem_req_size_o,
  output logic [27:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_req_ready_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  lsu_state_e  state_q, state_d;
  logic [27:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [31:0] store_word;
  logic        cnt_last;

  assign cnt_last = (counter_i == 3'd7);

  tinyqv_nibble_sreg u_sreg (
    .clk       (clk),
    .nibble_i  (store_nibble_i),
    .shifted_o (store_word)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath fields carry no reset; they are only observed once the FSM
  // has loaded them.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    size_q  <= size_d;
    rbuf_q  <= rbuf_d;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    rbuf_d  = rbuf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (address_ready_i && (is_store_i || is_load_i)) begin
          addr_d = addr_in_i;
          size_d = op_to_size(mem_op_i);
          if (is_store_i) begin
            wdata_d = store_word;
            state_d = ST_STORE_REQ;
          end else begin
            state_d = ST_LOAD_REQ;
          end
        end
      end
      ST_STORE_REQ: begin
        if (mem_req_ready_i) state_d = ST_IDLE;
      end
      ST_LOAD_REQ: begin
        if (mem_req_ready_i) begin
          if (mem_rvalid_i) begin
            rbuf_d  = mem_rdata_i;
            state_d = cnt_last ? ST_LOAD_DATA : ST_LOAD_HOLD;
          end else begin
            state_d = ST_LOAD_WAIT;
          end
        end
      end
      ST_LOAD_WAIT: begin
        if (mem_rvalid_i) begin
          rbuf_d  = mem_rdata_i;
          state_d = cnt_last ? ST_LOAD_DATA : ST_LOAD_HOLD;
        end
      end
      ST_LOAD_HOLD: begin
        if (cnt_last) state_d = ST_LOAD_DATA;
      end
      ST_LOAD_DATA: begin
        if (cnt_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req_valid_o   = 1'b0;
    mem_req_write_o   = 1'b0;
    load_data_ready_o = 1'b0;
    load_nibble_o     = 4'h0;
    busy_o            = (state_q != ST_IDLE);
    case (state_q)
      ST_STORE_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_write_o = 1'b1;
      end
      ST_LOAD_REQ: begin
        mem_req_valid_o = 1'b1;
      end
      ST_LOAD_DATA: begin
        load_data_ready_o = 1'b1;
        load_nibble_o     = rbuf_q[{counter_i, 2'b00} +: 4];
      end
      default: ;
    endcase
  end

  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign mem_req_size_o = size_q;

endmodule

// File: tb/tb_tinyqv_lsu.sv
// Self-checking bench for tinyqv_lsu: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_tinyqv_lsu;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  cnt;
  logic        ar, is_ld, is_st;
  logic [2:0]  op;
  logic [27:0] addr;
  logic [3:0]  nib;
  logic        ready, rvalid;
  logic [31:0] rdata;

  logic        ldr, busy, valid, write;
  logic [3:0]  lnib;
  logic [1:0]  size;
  logic [27:0] maddr;
  logic [31:0] wdata;

  int errors = 0;
  int checks = 0;
  int valid_seen = 0;

  always #5 clk = ~clk;

  tinyqv_lsu dut (
    .clk               (clk),
    .rstn              (rstn),
    .counter_i         (cnt),
    .address_ready_i   (ar),
    .is_load_i         (is_ld),
    .is_store_i        (is_st),
    .mem_op_i          (op),
    .addr_in_i         (addr),
    .store_nibble_i    (nib),
    .load_data_ready_o (ldr),
    .load_nibble_o     (lnib),
    .busy_o            (busy),
    .mem_req_valid_o   (valid),
    .mem_req_write_o   (write),
    .mem_req_size_o    (size),
    .mem_addr_o        (maddr),
    .mem_wdata_o       (wdata),
    .mem_req_ready_i   (ready),
    .mem_rvalid_i      (rvalid),
    .mem_rdata_i       (rdata)
  );

  // Reference model: one outstanding transaction described by flags.
  bit          m_req, m_wr, m_wait, m_held, m_dlv;
  logic [27:0] m_addr;
  logic [1:0]  m_size;
  logic [31:0] m_wdata, m_data;
  logic [3:0]  hist[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic got_data();
    m_data = rdata;
    if (cnt == 3'd7) m_dlv = 1'b1;
    else m_held = 1'b1;
  endtask

  task automatic model_step();
    logic [31:0] w;
    w = 32'(nib) << 28;
    if (hist.size() >= 7)
      for (int i = 0; i < 7; i++) w |= 32'(hist[hist.size() - 7 + i]) << (4 * i);
    if (!rstn) begin
      m_req = 0; m_wait = 0; m_held = 0; m_dlv = 0;
    end else if (m_dlv) begin
      if (cnt == 3'd7) m_dlv = 0;
    end else if (m_held) begin
      if (cnt == 3'd7) begin m_held = 0; m_dlv = 1; end
    end else if (m_req) begin
      if (ready) begin
        m_req = 0;
        if (!m_wr) begin
          if (rvalid) got_data();
          else m_wait = 1;
        end
      end
    end else if (m_wait) begin
      if (rvalid) begin m_wait = 0; got_data(); end
    end else if (ar && (is_st || is_ld)) begin
      m_req  = 1;
      m_wr   = is_st;
      m_addr = addr;
      m_size = (op[1:0] == 2'd0) ? 2'd0 : (op[1:0] == 2'd1) ? 2'd1 : 2'd2;
      m_wdata = w;
    end
    hist.push_back(nib);
    if (hist.size() > 8) void'(hist.pop_front());
  endtask

  task automatic compare_model();
    logic [3:0] en;
    en = m_dlv ? 4'((m_data >> (4 * int'(cnt))) & 32'hF) : 4'h0;
    chk("m_valid", 32'(valid), 32'(m_req));
    chk("m_write", 32'(write), 32'(m_req && m_wr));
    chk("m_busy", 32'(busy), 32'(m_req || m_wait || m_held || m_dlv));
    chk("m_ldr", 32'(ldr), 32'(m_dlv));
    chk("m_nibble", 32'(lnib), 32'(en));
    if (m_req) begin
      chk("m_addr", 32'(maddr), 32'(m_addr));
      chk("m_size", 32'(size), 32'(m_size));
      if (m_wr) chk("m_wdata", wdata, m_wdata);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1 cnt = cnt + 3'd1;
    #1 compare_model();
    if (valid) valid_seen++;
  endtask

  task automatic idle_in();
    ar = 0; is_ld = 0; is_st = 0; ready = 0; rvalid = 0;
  endtask

  task automatic align(input logic [2:0] k);
    while (cnt != k) cyc();
  endtask

  task automatic store_word(input logic [31:0] word, input logic [27:0] a, input int hold);
    logic [31:0] wv;
    wv = word;
    align(3'd0);
    for (int i = 0; i < 8; i++) begin
      nib = 4'((wv >> (4 * i)) & 32'hF);
      if (i == 7) begin ar = 1; is_st = 1; op = 3'b010; addr = a; end
      cyc();
    end
    idle_in();
    addr = 28'hFFFFFFF;
    nib = 4'($urandom);
    chk("st_valid", 32'(valid), 32'd1);
    chk("st_write", 32'(write), 32'd1);
    chk("st_size", 32'(size), 32'd2);
    chk("st_wdata", wdata, word);
    chk("st_addr", 32'(maddr), 32'(a));
    for (int i = 0; i < hold; i++) begin
      cyc();
      chk("bp_valid", 32'(valid), 32'd1);
      chk("bp_addr", 32'(maddr), 32'(a));
      chk("bp_wdata", wdata, word);
    end
    ready = 1;
    cyc();
    ready = 0;
    chk("st_done_busy", 32'(busy), 32'd0);
    chk("st_done_valid", 32'(valid), 32'd0);
  endtask

  typedef struct {
    bit ar; bit rdy; bit rv;
    bit ev; bit ebusy; bit eldr; logic [3:0] enib;
  } vec_t;

  vec_t tv[17];

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rstn = 0; cnt = 3'd0; idle_in(); op = 3'b000; addr = 28'h0; rdata = 32'h0; nib = 4'h0;
    for (int i = 0; i < 10; i++) begin nib = 4'($urandom); cyc(); end
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ldr", 32'(ldr), 32'd0);
    chk("rst_nibble", 32'(lnib), 32'd0);
    rstn = 1;

    // Store word with 3 clocks of request, then 10 clocks of backpressure.
    store_word(32'h12345678, 28'h0000100, 2);
    store_word(32'hCAFEF00D, 28'h0ABCDEF, 10);

    // Load byte vector table: address_ready at counter 7.
    for (int i = 0; i < 17; i++) tv[i] = '{0, 0, 0, 0, 1, 0, 4'h0};
    tv[0]  = '{1, 0, 0, 1, 1, 0, 4'h0};
    tv[1]  = '{0, 1, 0, 0, 1, 0, 4'h0};
    tv[6]  = '{0, 0, 1, 0, 1, 0, 4'h0};
    for (int i = 8; i < 16; i++) tv[i].eldr = 1;
    tv[8].enib = 4'h5;
    tv[9].enib = 4'hA;
    tv[16].ebusy = 0;
    align(3'd7);
    for (int i = 0; i < 17; i++) begin
      ar = tv[i].ar; is_ld = tv[i].ar; op = 3'b100; addr = 28'h0000203;
      ready = tv[i].rdy; rvalid = tv[i].rv; rdata = 32'h000000A5;
      cyc();
      chk($sformatf("tv%0d_valid", i), 32'(valid), 32'(tv[i].ev));
      chk($sformatf("tv%0d_busy", i), 32'(busy), 32'(tv[i].ebusy));
      chk($sformatf("tv%0d_ldr", i), 32'(ldr), 32'(tv[i].eldr));
      chk($sformatf("tv%0d_nib", i), 32'(lnib), 32'(tv[i].enib));
      if (tv[i].ev) begin
        chk($sformatf("tv%0d_addr", i), 32'(maddr), 32'h203);
        chk($sformatf("tv%0d_size", i), 32'(size), 32'd0);
      end
    end
    idle_in();

    // rvalid exactly at counter 7: data starts next clock, one round only.
    align(3'd5);
    ar = 1; is_ld = 1; op = 3'b001; addr = 28'h0000044;
    cyc();
    idle_in(); ready = 1;
    cyc();
    ready = 0; rvalid = 1; rdata = 32'h87654321;
    cyc();
    rvalid = 0;
    chk("b7_ldr", 32'(ldr), 32'd1);
    chk("b7_cnt", 32'(cnt), 32'd0);
    chk("b7_nib0", 32'(lnib), 32'h1);
    n = 1;
    for (int i = 0; i < 7; i++) begin cyc(); if (ldr) n++; end
    cyc();
    chk("b7_rounds", 32'(n), 32'd8);
    chk("b7_idle_busy", 32'(busy), 32'd0);

    // Second address_ready while a load is waiting for data is ignored.
    align(3'd0);
    valid_seen = 0;
    ar = 1; is_ld = 1; op = 3'b010; addr = 28'h0000300;
    cyc();
    idle_in(); ready = 1;
    cyc();
    ready = 0; ar = 1; is_ld = 1; addr = 28'h0000999;
    cyc();
    is_ld = 0; is_st = 1; addr = 28'h0000777;
    cyc();
    idle_in();
    chk("ov_addr", 32'(maddr), 32'h300);
    chk("ov_valid", 32'(valid), 32'd0);
    rvalid = 1; rdata = $urandom;
    cyc();
    rvalid = 0;
    for (int i = 0; i < 24 && busy; i++) cyc();
    chk("ov_done", 32'(busy), 32'd0);
    chk("ov_requests", 32'(valid_seen), 32'd1);

    // Reset during LOAD_DATA at counter 3, then stray rvalid.
    align(3'd5);
    ar = 1; is_ld = 1; op = 3'b010; addr = 28'h0000500;
    cyc();
    idle_in(); ready = 1; rvalid = 1; rdata = 32'hDEADBEEF;
    cyc();
    idle_in();
    align(3'd3);
    chk("rs_in_data", 32'(ldr), 32'd1);
    rstn = 0;
    cyc();
    chk("rs_ldr", 32'(ldr), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    rstn = 1; rvalid = 1;
    cyc(); cyc();
    rvalid = 0;
    chk("rs_stray_busy", 32'(busy), 32'd0);
    chk("rs_stray_ldr", 32'(ldr), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int k;
      k = $urandom_range(0, 5);
      rstn   = ($urandom_range(0, 199) != 0);
      ar     = (k < 3);
      is_ld  = (k == 0);
      is_st  = (k == 1);
      op     = 3'($urandom);
      addr   = 28'($urandom);
      nib    = 4'($urandom);
      ready  = 1'($urandom_range(0, 1));
      rvalid = ($urandom_range(0, 3) == 0);
      rdata  = $urandom;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tinyqv_lsu.md
TINYQV_LSU -- requirements
Module: tinyqv_lsu

Interface
REQ-001 SHALL have ports: clk in 1 clock; rstn in 1 reset, synchronous, active-low.
REQ-002 SHALL have core-side inputs: counter in 3 sub-cycle count; address_ready in 1 core address valid; is_load in 1; is_store in 1; mem_op in 3 size/sign; addr_in in 28 access address; store_nibble in 4 core data_out.
REQ-003 SHALL have core-side outputs: load_data_ready out 1 load nibbles valid; load_nibble out 4 load data to core; busy out 1 LSU not idle, decoder must stall memory instructions.
REQ-004 SHALL have memory-side outputs: mem_req_valid out 1; mem_req_write out 1; mem_req_size out 2 (00 byte, 01 half, 10 word); mem_addr out 28; mem_wdata out 32.
REQ-005 SHALL have memory-side inputs: mem_req_ready in 1 request accepted; mem_rvalid in 1 read data valid; mem_rdata in 32 right-justified read data.
REQ-006 SHALL have no parameters.

Function
REQ-007 SHALL shift store_nibble into a 32-bit register every clk: sreg <= {store_nibble, sreg[31:4]}.
REQ-008 SHALL use states IDLE, STORE_REQ, LOAD_REQ, LOAD_WAIT, LOAD_HOLD, LOAD_DATA.
REQ-009 In IDLE, on address_ready && is_store, SHALL latch mem_addr=addr_in, mem_wdata={store_nibble, sreg[31:4]}, size, and go to STORE_REQ.
REQ-010 In IDLE, on address_ready && is_load, SHALL latch addr and size and go to LOAD_REQ.
REQ-011 SHALL map mem_req_size from mem_op[1:0]: 00->00, 01->01, 10 and 11->10; mem_op[2] not forwarded.
REQ-012 mem_req_valid SHALL be 1 exactly in STORE_REQ and LOAD_REQ; addr/size/wdata/write SHALL be stable while valid && !ready.
REQ-013 mem_req_write SHALL be 1 in STORE_REQ, 0 otherwise.
REQ-014 STORE_REQ SHALL go to IDLE on mem_req_ready; LOAD_REQ SHALL go to LOAD_WAIT on mem_req_ready.
REQ-015 mem_rvalid SHALL be honoured in LOAD_REQ on the accepting cycle or in LOAD_WAIT; on it, SHALL capture mem_rdata into rbuf.
REQ-016 On rvalid capture, SHALL go to LOAD_DATA if counter==7, else LOAD_HOLD.
REQ-017 LOAD_HOLD SHALL go to LOAD_DATA when counter==7.
REQ-018 LOAD_DATA SHALL last exactly 8 clocks (counter 0..7), then go to IDLE at counter==7.
REQ-019 load_data_ready SHALL be 1 exactly in LOAD_DATA; load_nibble = rbuf[4*counter+3 : 4*counter] then, 0 otherwise.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 address_ready while not IDLE SHALL be ignored, with no state or latched-field change.
REQ-022 mem_rvalid outside LOAD_REQ-accept and LOAD_WAIT SHALL be ignored.
REQ-023 address_ready with neither is_load nor is_store SHALL be ignored.
REQ-024 Store latency SHALL be 1 clk from address_ready to mem_req_valid; load return SHALL be aligned to the next counter==0.

Reset
REQ-025 On rstn==0 at clk edge SHALL enter IDLE: mem_req_valid=0, load_data_ready=0, busy=0, load_nibble=0.
REQ-026 Reset mid-request or mid-LOAD_DATA SHALL abandon the access; no further valid or ready pulses.
REQ-027 mem_addr, mem_wdata, rbuf and sreg SHALL need no reset.

Structure
REQ-028 SHALL take state encoding and size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) from shared package tinyqv_lsu_pkg.
REQ-029 SHALL implement the REQ-007 store shift register as sub-module tinyqv_nibble_sreg (32-bit, 4-bit in).
REQ-030 SHALL be single clock domain, with no combinational path from mem_* inputs to core-side outputs.

Verification
REQ-031 Store word: stream nibbles of 0x12345678 LSB-first over counter 0..7, address_ready at 7, addr 0x0000100, mem_op 010 -> next clk valid=1, write=1, size=10, wdata=0x12345678; ready after 3 clks -> IDLE.
REQ-032 Load byte: addr 0x0000203, mem_op 100, ready immediate, rvalid after 5 clks with 0x000000A5 -> load_data_ready high for counter 0..7 of next round; nibbles 5,A,0,0,0,0,0,0.
REQ-033 Boundary: rvalid exactly at counter==7 -> LOAD_DATA the next clk (counter 0), no extra 8-clk round.
REQ-034 Overlap: second address_ready during LOAD_WAIT -> ignored; mem_addr unchanged, single request issued.
REQ-035 Reset in LOAD_DATA at counter 3 -> next clk load_data_ready=0, busy=0; stray rvalid later -> no effect.
REQ-036 Backpressure: ready low 10 clks with store pending -> valid, addr, wdata held constant every clk.
